// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit: operand select
// encodings and the per-stage shadow record.
package hazard_pkg;

   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // What the hazard unit remembers about an instruction after it leaves EX.
   typedef struct packed {
      reg_addr_t rd;
      logic      reg_write;
      logic      mem_read;
   } shadow_t;

   localparam shadow_t SHADOW_NONE = '{rd: '0, reg_write: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle between the ID/EX pipeline registers and the hazard unit.
// The pipeline side drives stage fields; the hazard unit returns controls.
interface hazard_forward_unit_if #(
   parameter int CNT_W = 16
);
   import hazard_pkg::*;

   reg_addr_t          RS1_ID;
   reg_addr_t          RS2_ID;
   reg_addr_t          RS1_EX;
   reg_addr_t          RS2_EX;
   reg_addr_t          RD_EX;
   logic               RegWrite_EX;
   logic               MemRead_EX;
   logic               PCSrc_EX;
   logic [1:0]         forwardA;
   logic [1:0]         forwardB;
   logic               PCWrite;
   logic               IF_ID_Write;
   logic               ID_EX_Bubble;
   logic               IF_ID_Flush;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   flush_cnt;

   modport master (
      output RS1_ID, RS2_ID, RS1_EX, RS2_EX, RD_EX,
      output RegWrite_EX, MemRead_EX, PCSrc_EX,
      input  forwardA, forwardB, PCWrite, IF_ID_Write,
      input  ID_EX_Bubble, IF_ID_Flush, stall_cnt, flush_cnt
   );

   modport slave (
      input  RS1_ID, RS2_ID, RS1_EX, RS2_EX, RD_EX,
      input  RegWrite_EX, MemRead_EX, PCSrc_EX,
      output forwardA, forwardB, PCWrite, IF_ID_Write,
      output ID_EX_Bubble, IF_ID_Flush, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_forward_unit_fwd_sel.sv
// Forwarding select for one EX source operand; the youngest in-flight writer
// wins and x0 is never forwarded.
module fwd_sel
   import hazard_pkg::*;
(
   input  reg_addr_t rs_i,
   input  shadow_t   mem_i,
   input  shadow_t   wb_i,
   output fwd_sel_e  sel_o
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_i.reg_write && (mem_i.rd != '0) && (mem_i.rd == rs_i);
   assign wb_hit  = wb_i.reg_write  && (wb_i.rd  != '0) && (wb_i.rd  == rs_i);

   always_comb begin
      // NOTE: default first so every path assigns sel_o and no latch is inferred.
      sel_o = FWD_REG;
      if (mem_hit) begin
         sel_o = FWD_MEM;
      end else if (wb_hit) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall,
// taken-branch flush and saturating event counters.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic                  clk,
   input logic                  reset,
   hazard_forward_unit_if.slave hz
);

   shadow_t          mem_q, mem_d;
   shadow_t          wb_q,  wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   fwd_sel_e sel_a;
   fwd_sel_e sel_b;
   logic     luh;
   logic     stall;
   logic     flush;

   fwd_sel u_fwd_a (.rs_i(hz.RS1_EX), .mem_i(mem_q), .wb_i(wb_q), .sel_o(sel_a));
   fwd_sel u_fwd_b (.rs_i(hz.RS2_EX), .mem_i(mem_q), .wb_i(wb_q), .sel_o(sel_b));

   // A stall or flush is suppressed while reset is held so the pending event is dropped.
   assign luh   = hz.MemRead_EX && (hz.RD_EX != '0) &&
                  ((hz.RD_EX == hz.RS1_ID) || (hz.RD_EX == hz.RS2_ID));
   assign flush = reset && hz.PCSrc_EX;
   assign stall = reset && luh && !hz.PCSrc_EX;

   // The EX instruction always advances, so shadows shift unconditionally.
   assign mem_d = '{rd: hz.RD_EX, reg_write: hz.RegWrite_EX, mem_read: hz.MemRead_EX};
   assign wb_d  = mem_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         mem_q       <= SHADOW_NONE;
         wb_q        <= SHADOW_NONE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.forwardA     = reset ? sel_a : FWD_REG;
   assign hz.forwardB     = reset ? sel_b : FWD_REG;
   assign hz.PCWrite      = !stall;
   assign hz.IF_ID_Write  = !stall;
   assign hz.ID_EX_Bubble = stall || flush;
   assign hz.IF_ID_Flush  = flush;
   assign hz.stall_cnt    = stall_cnt_q;
   assign hz.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios plus
// random traffic against a history-based reference model.
module tb_hazard_forward_unit;

   localparam int CNT_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   hazard_forward_unit_if #(.CNT_W(CNT_W)) hz ();

   hazard_forward_unit #(.CNT_W(CNT_W)) dut (
      .clk  (clk),
      .reset(reset),
      .hz   (hz)
   );

   // Reference: list of instructions that left EX, most recent first.
   typedef struct {
      int rd;
      bit rw;
      bit mr;
   } ex_rec_t;

   ex_rec_t hist[$];
   int      m_stall;
   int      m_flush;
   int      n_tests = 0;
   int      n_fail  = 0;

   // Values observed in the most recent cycle, for directed checks.
   int obs_fa, obs_fb, obs_pcw, obs_ifw, obs_bub, obs_flu, obs_scnt, obs_fcnt;

   task automatic check(input string tag, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int fwd_model(input int rs);
      if (rs == 0) return 0;
      for (int age = 0; age < 2; age++)
         if (hist[age].rw && hist[age].rd == rs) return (age == 0) ? 2 : 1;
      return 0;
   endfunction

   function automatic ex_rec_t empty_rec();
      ex_rec_t r;
      r.rd = 0; r.rw = 1'b0; r.mr = 1'b0;
      return r;
   endfunction

   task automatic clear_model();
      hist.delete();
      hist.push_front(empty_rec());
      hist.push_front(empty_rec());
      m_stall = 0;
      m_flush = 0;
   endtask

   // One clock cycle: drive at negedge, compare before the rising edge, then advance the model.
   task automatic cyc(input bit rst_n, input int rs1_id, input int rs2_id,
                      input int rs1_ex, input int rs2_ex, input int rd_ex,
                      input bit rw, input bit mr, input bit pc, input bit chk);
      int  e_fa, e_fb;
      bit  luh, e_stall, e_flush;
      ex_rec_t r;
      @(negedge clk);
      reset          = rst_n;
      hz.RS1_ID      = 5'(rs1_id);
      hz.RS2_ID      = 5'(rs2_id);
      hz.RS1_EX      = 5'(rs1_ex);
      hz.RS2_EX      = 5'(rs2_ex);
      hz.RD_EX       = 5'(rd_ex);
      hz.RegWrite_EX = rw;
      hz.MemRead_EX  = mr;
      hz.PCSrc_EX    = pc;
      #1;
      obs_fa   = int'(hz.forwardA);
      obs_fb   = int'(hz.forwardB);
      obs_pcw  = int'(hz.PCWrite);
      obs_ifw  = int'(hz.IF_ID_Write);
      obs_bub  = int'(hz.ID_EX_Bubble);
      obs_flu  = int'(hz.IF_ID_Flush);
      obs_scnt = int'(hz.stall_cnt);
      obs_fcnt = int'(hz.flush_cnt);

      luh     = mr && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);
      e_flush = rst_n && pc;
      e_stall = rst_n && luh && !pc;
      e_fa    = rst_n ? fwd_model(rs1_ex) : 0;
      e_fb    = rst_n ? fwd_model(rs2_ex) : 0;

      if (chk) begin
         check("forwardA",     obs_fa,  e_fa);
         check("forwardB",     obs_fb,  e_fb);
         check("PCWrite",      obs_pcw, !e_stall);
         check("IF_ID_Write",  obs_ifw, !e_stall);
         check("ID_EX_Bubble", obs_bub, e_stall || e_flush);
         check("IF_ID_Flush",  obs_flu, e_flush);
         check("stall_cnt",    obs_scnt, m_stall);
         check("flush_cnt",    obs_fcnt, m_flush);
         check("no_load_fwdA", (obs_fa == 2 && hist[0].mr), 0);
         check("no_load_fwdB", (obs_fb == 2 && hist[0].mr), 0);
      end

      @(posedge clk);
      if (!rst_n) begin
         clear_model();
      end else begin
         r.rd = rd_ex; r.rw = rw; r.mr = mr;
         hist.push_front(r);
         void'(hist.pop_back());
         if (e_stall && m_stall < CNT_MAX) m_stall++;
         if (e_flush && m_flush < CNT_MAX) m_flush++;
      end
   endtask

   task automatic idle(input bit chk);
      cyc(1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, chk);
   endtask

   task automatic do_reset();
      cyc(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      clear_model();
      reset = 1'b0;
      hz.RS1_ID = '0; hz.RS2_ID = '0; hz.RS1_EX = '0; hz.RS2_EX = '0;
      hz.RD_EX = '0; hz.RegWrite_EX = 1'b0; hz.MemRead_EX = 1'b0; hz.PCSrc_EX = 1'b0;

      // Reset held 3 cycles with random inputs; the first edge has not yet cleared the counters.
      for (int i = 0; i < 3; i++)
         cyc(1'b0, $urandom_range(31), $urandom_range(31), $urandom_range(31),
             $urandom_range(31), $urandom_range(31), 1'($urandom), 1'($urandom),
             1'($urandom), i != 0);
      check("rst_fa",  obs_fa, 0);
      check("rst_pcw", obs_pcw, 1);
      check("rst_cnt", obs_scnt + obs_fcnt, 0);

      // EX->EX forward from MEM.
      cyc(1'b1, 0, 0, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 0, 0, 5, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("exex_fa", obs_fa, 2);
      check("exex_fb", obs_fb, 0);

      // Double hazard: MEM wins, then only WB matches.
      cyc(1'b1, 0, 0, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 0, 0, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 0, 0, 0, 5, 9, 1'b1, 1'b0, 1'b0, 1'b1);
      check("dbl_mem_fb", obs_fb, 2);
      cyc(1'b1, 0, 0, 0, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("dbl_wb_fb", obs_fb, 1);

      // x0 is never forwarded, and a load to x0 never stalls.
      cyc(1'b1, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
      check("x0_fa", obs_fa, 0);
      check("x0_load_pcw", obs_pcw, 1);

      // Load-use: exactly one stall cycle, then WB forwarding to the consumer.
      do_reset();
      cyc(1'b1, 1, 7, 0, 0, 7, 1'b1, 1'b1, 1'b0, 1'b1);
      check("lu_pcw", obs_pcw, 0);
      check("lu_ifw", obs_ifw, 0);
      check("lu_bub", obs_bub, 1);
      cyc(1'b1, 1, 7, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("lu_release_pcw", obs_pcw, 1);
      cyc(1'b1, 0, 0, 1, 7, 3, 1'b1, 1'b0, 1'b0, 1'b1);
      check("lu_fb", obs_fb, 1);
      check("lu_stall_cnt", obs_scnt, 1);

      // Reset mid-stall drops the event; the next cycle is clean.
      cyc(1'b0, 7, 0, 0, 0, 7, 1'b1, 1'b1, 1'b0, 1'b1);
      check("rst_stall_pcw", obs_pcw, 1);
      idle(1'b1);
      check("rst_stall_cnt", obs_scnt, 0);

      // Branch beats a simultaneous load-use.
      cyc(1'b1, 7, 0, 0, 0, 7, 1'b1, 1'b1, 1'b1, 1'b1);
      check("br_flush", obs_flu, 1);
      check("br_pcw", obs_pcw, 1);
      check("br_bub", obs_bub, 1);
      idle(1'b1);
      check("br_flush_cnt", obs_fcnt, 1);
      check("br_stall_cnt", obs_scnt, 0);

      // Flush counter saturation.
      do_reset();
      for (int i = 0; i < CNT_MAX + 4; i++)
         cyc(1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      check("sat_flush_cnt", obs_fcnt, CNT_MAX);

      // Random legal traffic: a load in MEM is never consumed directly from EX.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         int rs1_ex, rs2_ex;
         rs1_ex = $urandom_range(7);
         rs2_ex = $urandom_range(7);
         if (hist[0].mr && hist[0].rw && hist[0].rd != 0) begin
            if (rs1_ex == hist[0].rd) rs1_ex = 0;
            if (rs2_ex == hist[0].rd) rs2_ex = 0;
         end
         cyc(($urandom_range(49) != 0), $urandom_range(7), $urandom_range(7),
             rs1_ex, rs2_ex, $urandom_range(7), 1'($urandom), ($urandom_range(3) == 0),
             ($urandom_range(5) == 0), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
